// File: rtl/acam_pkg.sv
// rtl/acam_pkg.sv - shared types and constants for the acoustic-camera delay scheduler
package acam_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CALC    = 2'd2,
        ST_PUBLISH = 2'd3
    } sched_state_e;

    // Default section depth, engine stall tolerance and delay-index width
    localparam int FRAMES_DEF  = 30;
    localparam int TIMEOUT_DEF = 500;
    localparam int TDW_DEF     = 4;

    // Frame-strobe bit positions for each microphone pair
    localparam int PAIR0_A_BIT = 0;
    localparam int PAIR0_B_BIT = 1;
    localparam int PAIR1_A_BIT = 2;
    localparam int PAIR1_B_BIT = 3;

endpackage

// File: rtl/frame_pairer.sv
// rtl/frame_pairer.sv - sticky-bit pairing of two mic frame strobes into one frame event
module frame_pairer (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    input  logic stb_a_i,
    input  logic stb_b_i,
    output logic evt_o
);

    logic hit_a_q, hit_a_d;
    logic hit_b_q, hit_b_d;

    // An event completes as soon as each side has either a held hit or a strobe this cycle
    assign evt_o = en_i & (hit_a_q | stb_a_i) & (hit_b_q | stb_b_i);

    // On an event the held hits are consumed; a strobe landing on a side that was
    // already held belongs to the next frame, so it re-sets that side (set beats clear)
    always_comb begin
        hit_a_d = hit_a_q;
        hit_b_d = hit_b_q;
        if (clr_i) begin
            hit_a_d = 1'b0;
            hit_b_d = 1'b0;
        end else if (en_i) begin
            if (evt_o) begin
                hit_a_d = hit_a_q & stb_a_i;
                hit_b_d = hit_b_q & stb_b_i;
            end else begin
                hit_a_d = hit_a_q | stb_a_i;
                hit_b_d = hit_b_q | stb_b_i;
            end
        end
    end

    // Sticky hit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_a_q <= 1'b0;
            hit_b_q <= 1'b0;
        end else begin
            hit_a_q <= hit_a_d;
            hit_b_q <= hit_b_d;
        end
    end

endmodule

// File: rtl/delay_calc_sched.sv
// rtl/delay_calc_sched.sv - capture/calc/publish sequencer for the time-delay estimator (option: DELAY_SCHED_LEVEL_GATE_EN)
module delay_calc_sched
    import acam_pkg::*;
#(
    parameter int FRAMES  = FRAMES_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TDW     = TDW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     frame_vld,
    input  logic           calc_done,
    input  logic [TDW-1:0] calc_td,
    input  logic           level_ok,
    output logic           pair_sel,
    output logic           buf_we,
    output logic [4:0]     buf_addr,
    output logic           calc_start,
    output logic [TDW-1:0] td0,
    output logic [TDW-1:0] td1,
    output logic           td_valid,
    output logic           calc_free,
    output logic           timeout_err
);

`ifdef DELAY_SCHED_LEVEL_GATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    localparam int             TOW       = $clog2(TIMEOUT + 2);
    localparam logic [4:0]     LAST_ADDR = 5'(FRAMES - 1);
    localparam logic [TOW-1:0] TO_LIMIT  = TOW'(TIMEOUT);
    localparam logic [TOW-1:0] TO_SAT    = TOW'(TIMEOUT + 1);

    sched_state_e   state_q;
    logic [4:0]     frame_cnt_q;
    logic [TOW-1:0] to_cnt_q;
    logic [TDW-1:0] td_hold_q;
    logic           lvl_hold_q;
    logic           pair_sel_q;
    logic           buf_we_q;
    logic [4:0]     buf_addr_q;
    logic           calc_start_q;
    logic [TDW-1:0] td0_q, td1_q;
    logic           td_valid_q;
    logic           calc_free_q;
    logic           timeout_err_q;

    logic stb_a, stb_b, stb_any;
    logic pair_evt, pair_clr, to_abort, pub_ok;

    // Input mux: only the active pair's strobes reach the pairer and the stall counter
    assign stb_a   = pair_sel_q ? frame_vld[PAIR1_A_BIT] : frame_vld[PAIR0_A_BIT];
    assign stb_b   = pair_sel_q ? frame_vld[PAIR1_B_BIT] : frame_vld[PAIR0_B_BIT];
    assign stb_any = stb_a | stb_b;

    assign to_abort = (state_q == ST_CALC) && !calc_done && stb_any && (to_cnt_q == TO_LIMIT);
    assign pair_clr = (state_q == ST_PUBLISH) || to_abort;
    assign pub_ok   = !GATE_EN || lvl_hold_q;

    frame_pairer u_pairer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == ST_CAPTURE),
        .clr_i   (pair_clr),
        .stb_a_i (stb_a),
        .stb_b_i (stb_b),
        .evt_o   (pair_evt)
    );

    // Main sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            frame_cnt_q   <= '0;
            to_cnt_q      <= '0;
            td_hold_q     <= '0;
            lvl_hold_q    <= 1'b0;
            pair_sel_q    <= 1'b0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            calc_start_q  <= 1'b0;
            td0_q         <= '0;
            td1_q         <= '0;
            td_valid_q    <= 1'b0;
            calc_free_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            buf_we_q      <= 1'b0;
            td_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            // The only write still high inside CALC is the section's last one
            calc_start_q  <= (state_q == ST_CALC) && buf_we_q;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (pair_evt) begin
                        buf_we_q   <= 1'b1;
                        buf_addr_q <= frame_cnt_q;
                        if (frame_cnt_q == LAST_ADDR) begin
                            frame_cnt_q <= '0;
                            to_cnt_q    <= '0;
                            state_q     <= ST_CALC;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 5'd1;
                        end
                    end
                end
                ST_CALC: begin
                    if (calc_done) begin
                        td_hold_q  <= calc_td;
                        lvl_hold_q <= level_ok;
                        state_q    <= ST_PUBLISH;
                    end else if (to_abort) begin
                        to_cnt_q      <= TO_SAT;
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_CAPTURE;
                    end else if (stb_any && (to_cnt_q != TO_SAT)) begin
                        to_cnt_q <= to_cnt_q + TOW'(1);
                    end
                end
                ST_PUBLISH: begin
                    if (pub_ok) begin
                        if (pair_sel_q) begin
                            td1_q <= td_hold_q;
                        end else begin
                            td0_q <= td_hold_q;
                        end
                        td_valid_q <= 1'b1;
                    end
                    calc_free_q <= ~calc_free_q;
                    pair_sel_q  <= ~pair_sel_q;
                    state_q     <= ST_CAPTURE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pair_sel    = pair_sel_q;
    assign buf_we      = buf_we_q;
    assign buf_addr    = buf_addr_q;
    assign calc_start  = calc_start_q;
    assign td0         = td0_q;
    assign td1         = td1_q;
    assign td_valid    = td_valid_q;
    assign calc_free   = calc_free_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/delay_calc_sched.md
# delay_calc_sched

Clocked controller that sequences the acoustic-camera time-delay estimator. Alternates between microphone pair 0 (mics 1/2) and pair 1 (mics 3/4), pairs per-mic frame strobes into joint frame events, and drives the write side of the two 30-entry frame buffers. Starts the correlation engine once a section is full, publishes the per-pair delay, and recovers from a stalled engine by timeout. Sits between the I2S frame deserialisers and the delay-correlation datapath; `calc_free` feeds the PS.

## Interface
- `FRAMES`, 30: frames per section (buffer depth).
- `TIMEOUT`, 500: frame strobes tolerated in CALC before abort.
- `TDW`, 4: delay-index width.
- `clk`  in  1  system clock, all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frame_vld`  in  4  one-cycle strobe per mic (bit0 = mic1 … bit3 = mic4), synchronous to `clk`.
- `calc_done`  in  1  one-cycle pulse from the correlation engine.
- `calc_td`  in  TDW  engine delay result, valid with `calc_done`.
- `level_ok`  in  1  engine level-threshold flag, valid with `calc_done`.
- `pair_sel`  out  1  active pair; steers the input muxes (0: SDATA1/2, 1: SDATA3/4).
- `buf_we`  out  1  write strobe to both frame buffers.
- `buf_addr`  out  5  buffer write address, 0..FRAMES-1.
- `calc_start`  out  1  one-cycle engine start pulse.
- `td0`, `td1`  out  TDW  last published delay for pair 0 / pair 1.
- `td_valid`  out  1  one-cycle pulse when `td0`/`td1` updates.
- `calc_free`  out  1  toggles once per completed calculation.
- `timeout_err`  out  1  one-cycle pulse on engine abort.

## Operation
- States: IDLE → CAPTURE → CALC → PUBLISH → CAPTURE. IDLE lasts one cycle after reset release.
- CAPTURE: sticky bits `hit_a`/`hit_b` latch the two strobes of the active pair (bits 0/1 or 2/3). Inactive-pair strobes are ignored.
  - When both bits are set: one frame event. Issue `buf_we` with `buf_addr` = frame count, clear both bits, increment the count.
  - A strobe arriving in the clearing cycle re-sets its bit (set wins over clear).
  - A repeated strobe on an already-set bit is absorbed.
- After write FRAMES-1: go to CALC, pulse `calc_start`, reset frame count to 0.
- CALC: wait for `calc_done`. Count every active-pair strobe; no buffer writes. If the count exceeds TIMEOUT: pulse `timeout_err`, keep `pair_sel`, clear the sticky bits, return to CAPTURE. Outputs do not update.
- PUBLISH (one cycle): store `calc_td` into `td0` or `td1` per `pair_sel`, pulse `td_valid`, toggle `calc_free`, toggle `pair_sel`, clear the sticky bits, go to CAPTURE.
- `calc_done` outside CALC is ignored.
- Reset values: state IDLE, `pair_sel`=0, `buf_we`=0, `buf_addr`=0, `calc_start`=0, `td0`=`td1`=0, `td_valid`=0, `calc_free`=0, `timeout_err`=0, counters 0.
- Reset mid-section discards the partial section; capture restarts at address 0 on pair 0.

## Timing
- `buf_we`/`buf_addr` are registered: asserted the cycle after the second strobe of a pair is sampled.
- `calc_start` is asserted the cycle after the last `buf_we`.
- PUBLISH is entered the cycle after `calc_done` is sampled. `td_valid`, new `td*`, and toggled `calc_free`/`pair_sel` appear the following cycle.
- Minimum spacing between `calc_start` and the next section's first `buf_we`: 3 cycles.
- The timeout counter saturates at TIMEOUT+1. `timeout_err` fires exactly once per abort.

## Configuration
- `DELAY_SCHED_LEVEL_GATE_EN` defined: in PUBLISH, `td0`/`td1` update and `td_valid` pulses only when `level_ok`=1. `calc_free` and `pair_sel` toggle regardless.
- Not defined: `level_ok` is ignored and every completion publishes.

## Structure
- Shared package `acam_pkg`: the state enum, FRAMES/TIMEOUT defaults, TDW, and the pair-to-strobe-bit mapping constants.
- One sub-module `frame_pairer`: sticky-bit strobe pairing for one pair, with set-over-clear priority. The pair mux selects which two strobes feed it.

## Test plan
- Pair 0 capture: 30 simultaneous strobes on bits 0/1 → 30 `buf_we` at addr 0..29, then `calc_start` one cycle after the addr-29 write; `pair_sel` stays 0.
- Skewed strobes: bit0, then bit1 5 cycles later → exactly one `buf_we`, one cycle after bit1. A second bit0 before bit1 → still one write.
- Completion: `calc_done` with `calc_td`=7 → `td0`=7, `td_valid` pulse, `calc_free` 0→1, `pair_sel` 0→1. The next section captures only bits 2/3.
- Timeout: withhold `calc_done` and send 501 pair strobes → one `timeout_err`, `td0` unchanged, `pair_sel` unchanged, capture restarts at addr 0.
- Gate (macro on): `calc_done` with `level_ok`=0 and `calc_td`=3 → `td1` holds its old value, no `td_valid`, `calc_free` still toggles.
- Reset: assert `rst_n`=0 at addr 12 → all outputs return to reset values asynchronously; after release, the first write is at addr 0 on pair 0.
